i2c_master_arbiter: RTL

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_arb_pkg.sv | 17 +
 rtl/i2c_master_arbiter_rr_pick.sv | 32 +++
 rtl/i2c_master_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
// State encoding plus the address/length field widths.
package i2c_arb_pkg;

    localparam int LEN_W  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_XFER,
        ST_STOP,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, with wrap.
// Purely combinational; returns one-hot grant and its index.
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // scan NUM_REQ candidates starting at ptr, keep the first hit
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add the stalled-transaction watchdog.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [ADDR_W*NUM_REQ-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]         req_rw_i,
    input  logic [LEN_W*NUM_REQ-1:0]   req_len_i,
    input  logic [DATA_W*NUM_REQ-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       wdata_ack_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rdata_valid_o,
    output logic                       done_o,
    output logic                       nack_o,
    output logic                       timeout_o,
    output logic                       m_start_o,
    output logic                       m_stop_o,
    output logic                       m_rw_o,
    output logic [ADDR_W-1:0]          m_addr_o,
    output logic [DATA_W-1:0]          m_wdata_o,
    input  logic                       m_byte_done_i,
    input  logic                       m_ack_err_i,
    input  logic [DATA_W-1:0]          m_rdata_i,
    input  logic                       m_idle_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               nack_q, nack_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               wd_force;
    logic               stop_exit;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    logic            wd_active;
    logic            wd_hit;

    // count stalled cycles; a byte or an idle master restarts the count
    always_comb begin
        wd_active = (state_q == ST_START) || (state_q == ST_XFER) ||
                    (state_q == ST_STOP);
        wd_d      = '0;
        wd_hit    = 1'b0;
        to_d      = to_q;
        if (wd_active && !m_byte_done_i && !m_idle_i) begin
            wd_d   = wd_q + 1'b1;
            wd_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
        end
        if (state_q == ST_IDLE && |req_i) to_d = 1'b0;
        if (wd_hit) to_d = 1'b1;
    end

    // watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign wd_force  = wd_hit;
    assign stop_exit = m_idle_i | to_q;
    assign timeout_o = done_q & to_q;
`else
    assign wd_force  = 1'b0;
    assign stop_exit = m_idle_i;
    assign timeout_o = 1'b0;
`endif

    // transaction sequencing and registered master controls
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        cnt_d    = cnt_q;
        nack_d   = nack_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        start_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_START;
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    addr_d  = req_addr_i[ADDR_W*int'(pick_idx) +: ADDR_W];
                    rw_d    = req_rw_i[pick_idx];
                    cnt_d   = req_len_i[LEN_W*int'(pick_idx) +: LEN_W];
                    nack_d  = 1'b0;
                    start_d = 1'b1;
                end
            end
            ST_START: begin
                if (m_ack_err_i) begin
                    nack_d  = 1'b1;
                    state_d = ST_STOP;
                end else if (cnt_q == '0) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (m_ack_err_i) begin
                    nack_d  = 1'b1;
                    state_d = ST_STOP;
                end else if (m_byte_done_i) begin
                    cnt_d = cnt_q - 1'b1;
                    if (rw_q) begin
                        rdata_d  = m_rdata_i;
                        rvalid_d = 1'b1;
                    end
                    if (cnt_q == LEN_W'(1)) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop_exit) state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                         : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_force) begin
            state_d = (state_q == ST_STOP) ? ST_DONE : ST_STOP;
        end
        done_d = (state_d == ST_DONE);
        stop_d = (state_d == ST_STOP) ||
                 (state_d == ST_XFER  && cnt_d == LEN_W'(1)) ||
                 (state_d == ST_START && cnt_d == '0);
    end

    // state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            cnt_q    <= '0;
            nack_q   <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            cnt_q    <= cnt_d;
            nack_q   <= nack_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign m_start_o     = start_q;
    assign m_stop_o      = stop_q;
    assign m_rw_o        = rw_q;
    assign m_addr_o      = addr_q;
    assign done_o        = done_q;
    assign nack_o        = done_q & nack_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign wdata_ack_o   = (state_q == ST_XFER) && !rw_q &&
                           m_byte_done_i && !m_ack_err_i;
    assign m_wdata_o     = (state_q == ST_XFER)
                         ? req_wdata_i[DATA_W*int'(idx_q) +: DATA_W]
                         : '0;

endmodule
